// File: rtl/music_pkg.sv
// Shared types for the music sequencer: FSM states, slot index, memory depth.
// Build option: MUSIC_SEQ_LOOP_EN (looped playback) is handled in the top.
package music_pkg;

    localparam int NUM_SLOTS = 16;

    typedef logic [3:0] slot_t;

    typedef enum logic [2:0] {
        IDLE,
        REC_WRITE,
        REC_DRAW,
        PLAY_START,
        PLAY_HOLD,
        PLAY_END
    } state_t;

endpackage

// File: rtl/music_sequencer_tick_timer.sv
// Loadable up-counter with terminal-count compare, shared by all hold timing.
// Exposes its next value so the owner can register outputs that depend on it.
module tick_timer #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic [W-1:0] count_nxt,
    output logic         hit
);

    assign count_nxt = clr ? '0 : count + W'(1);
    assign hit       = (count == limit);

    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else       count <= count_nxt;
    end

endmodule

// File: rtl/music_sequencer.sv
// Control FSM sequencing note record and playback for the note datapath.
// Define MUSIC_SEQ_LOOP_EN to loop playback until stop_req or reset.
module music_sequencer
    import music_pkg::*;
#(
    parameter int unsigned NOTE_TICKS = 25_000_000,
    parameter int unsigned DRAW_TICKS = 512
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       record_req,
    input  logic       play_req,
    input  logic       stop_req,
    output logic       ld_note,
    output logic       ld_play,
    output logic [3:0] note_counter,
    output logic       display_note,
    output logic       next_note_en,
    output logic [4:0] note_count,
    output logic       full,
    output logic       busy
);

    localparam int TW = 25;

    state_t          state, state_nxt;
    logic [4:0]      count_nxt;
    slot_t           ctr_nxt;
    logic            step, clr, hit, play_nxt;
    logic [TW-1:0]   tick, tick_nxt, limit;

    // REC_WRITE reuses the timer to hold ld_note for exactly two cycles
    always_comb begin
        case (state)
            REC_WRITE: limit = TW'(1);
            REC_DRAW:  limit = TW'(DRAW_TICKS - 1);
            default:   limit = TW'(NOTE_TICKS - 1);
        endcase
    end

    tick_timer #(.W(TW)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .limit     (limit),
        .count     (tick),
        .count_nxt (tick_nxt),
        .hit       (hit)
    );

    always_comb begin
        state_nxt = state;
        count_nxt = note_count;
        ctr_nxt   = note_counter;
        step      = 1'b0;
        unique case (state)
            IDLE: begin
                ctr_nxt = '0;
                if (play_req && note_count != 5'd0)
                    state_nxt = PLAY_START;
                else if (record_req && !full)
                    state_nxt = REC_WRITE;
            end
            REC_WRITE: begin
                if (hit) begin
                    state_nxt = REC_DRAW;
                    count_nxt = note_count + 5'd1;
                end
            end
            REC_DRAW: begin
                if (hit) state_nxt = IDLE;
            end
            PLAY_START: begin
                state_nxt = PLAY_HOLD;
            end
            PLAY_HOLD: begin
                if (stop_req) begin
                    state_nxt = IDLE;
                    ctr_nxt   = '0;
                end else if (hit) begin
                    if (note_counter == slot_t'(note_count - 5'd1)) begin
`ifdef MUSIC_SEQ_LOOP_EN
                        ctr_nxt = '0;
                        step    = 1'b1;
`else
                        state_nxt = PLAY_END;
                        ctr_nxt   = '0;
`endif
                    end else begin
                        ctr_nxt = note_counter + slot_t'(1);
                        step    = 1'b1;
                    end
                end
            end
            PLAY_END: begin
                state_nxt = IDLE;
                ctr_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                ctr_nxt   = '0;
            end
        endcase
        // PLAY_START is tick 0 of the first note, so entering PLAY_HOLD keeps counting
        clr = step ||
              (state_nxt != state && state_nxt != PLAY_HOLD);
        play_nxt = (state_nxt == PLAY_START) ||
                   (state_nxt == PLAY_HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ld_note      <= 1'b0;
            ld_play      <= 1'b0;
            note_counter <= '0;
            display_note <= 1'b0;
            next_note_en <= 1'b0;
            note_count   <= '0;
            full         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            ld_note      <= (state_nxt == REC_WRITE);
            ld_play      <= play_nxt;
            note_counter <= ctr_nxt;
            display_note <= (state_nxt == REC_DRAW) ||
                            (play_nxt && tick_nxt < TW'(DRAW_TICKS));
            next_note_en <= (state_nxt == PLAY_START) || step;
            note_count   <= count_nxt;
            full         <= (count_nxt == 5'(NUM_SLOTS));
            busy         <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_music_sequencer.sv
// Scoreboard bench for music_sequencer with NOTE_TICKS=8, DRAW_TICKS=3.
// Driver queues timestamped output events; a negedge monitor pops and compares.
module tb_music_sequencer;

    localparam int K_LDR = 0;
    localparam int K_LDF = 1;
    localparam int K_DR  = 2;
    localparam int K_DF  = 3;
    localparam int K_NN  = 4;
    localparam int K_PF  = 5;
    localparam int K_BF  = 6;

    typedef struct {
        int kind;
        int cyc;
        int data;
    } ev_t;

    logic       clk;
    logic       reset;
    logic       record_req;
    logic       play_req;
    logic       stop_req;
    logic       ld_note;
    logic       ld_play;
    logic [3:0] note_counter;
    logic       display_note;
    logic       next_note_en;
    logic [4:0] note_count;
    logic       full;
    logic       busy;

    ev_t   q[$];
    int    cyc;
    int    vecs;
    int    errs;
    bit    mon_en;
    logic  p_ld, p_disp, p_play, p_busy;
    string kn[7] = '{"ld_rise", "ld_fall", "disp_rise", "disp_fall",
                     "next_note", "play_fall", "busy_fall"};

    music_sequencer #(
        .NOTE_TICKS (8),
        .DRAW_TICKS (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .record_req   (record_req),
        .play_req     (play_req),
        .stop_req     (stop_req),
        .ld_note      (ld_note),
        .ld_play      (ld_play),
        .note_counter (note_counter),
        .display_note (display_note),
        .next_note_en (next_note_en),
        .note_count   (note_count),
        .full         (full),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int k, input int c, input int d);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic got(input int k, input int d);
        ev_t e;
        vecs++;
        if (q.size() == 0) begin
            errs++;
            $display("FAIL %s unexpected at cycle %0d data %0d", kn[k], cyc, d);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.data != d) begin
                errs++;
                $display("FAIL %s: got %s cyc %0d data %0d, want %s cyc %0d data %0d",
                         kn[e.kind], kn[k], cyc, d, kn[e.kind], e.cyc, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (ld_note && !p_ld)       got(K_LDR, int'(note_count));
            if (!ld_note && p_ld)       got(K_LDF, int'(note_count));
            if (display_note && !p_disp) got(K_DR, int'(note_counter));
            if (!display_note && p_disp) got(K_DF, int'(note_counter));
            if (next_note_en)           got(K_NN, int'(note_counter));
            if (!ld_play && p_play)     got(K_PF, int'(note_counter));
            if (!busy && p_busy)        got(K_BF, int'({full, note_count}));
        end
        p_ld   = ld_note;
        p_disp = display_note;
        p_play = ld_play;
        p_busy = busy;
    end

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_play;
        play_req = 1'b1;
        @(negedge clk);
        play_req = 1'b0;
    endtask

    task automatic pulse_stop;
        stop_req = 1'b1;
        @(negedge clk);
        stop_req = 1'b0;
    endtask

    // n = slots filled before the request; a full memory expects no events
    task automatic record(input int n);
        int t;
        t = cyc;
        if (n < 16) begin
            push(K_LDR, t + 1, n);
            push(K_LDF, t + 3, n + 1);
            push(K_DR,  t + 3, 0);
            push(K_DF,  t + 6, 0);
            push(K_BF,  t + 6, (n + 1 == 16 ? 32 : 0) + n + 1);
        end
        record_req = 1'b1;
        @(negedge clk);
        record_req = 1'b0;
        wait_to(t + 7);
    endtask

    task automatic push_notes(input int t, input int n, input int notes);
        for (int k = 0; k < notes; k++) begin
            push(K_DR, t + 1 + 8 * k, k % n);
            push(K_NN, t + 1 + 8 * k, k % n);
            push(K_DF, t + 4 + 8 * k, k % n);
        end
    endtask

    initial begin
        int t;
        int t1;
        vecs = 0;
        errs = 0;
        mon_en = 1'b0;
        reset = 1'b1;
        record_req = 1'b0;
        play_req = 1'b0;
        stop_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            int'({ld_note, ld_play, note_counter, display_note,
                  next_note_en, note_count, full, busy}), 0);
        reset = 1'b0;
        mon_en = 1'b1;

        t = cyc;
        pulse_play;
        wait_to(t + 6);
        chk("play_empty_busy", int'(busy), 0);
        chk("play_empty_ld_play", int'(ld_play), 0);

        for (int i = 0; i < 3; i++) record(i);
        chk("count_after_3", int'(note_count), 3);

`ifndef MUSIC_SEQ_LOOP_EN
        t = cyc;
        push_notes(t, 3, 3);
        push(K_PF, t + 25, 0);
        push(K_BF, t + 26, 3);
        pulse_play;
        wait_to(t + 28);
`endif

        // stop during the second note
        t = cyc;
        push_notes(t, 3, 1);
        push(K_DR, t + 9, 1);
        push(K_NN, t + 9, 1);
        push(K_DF, t + 11, 0);
        push(K_PF, t + 11, 0);
        push(K_BF, t + 11, 3);
        pulse_play;
        wait_to(t + 10);
        pulse_stop;
        wait_to(t + 12);

        // simultaneous record+play: play wins, then stop mid-note
        t1 = cyc;
        push_notes(t1, 3, 1);
        push(K_PF, t1 + 6, 0);
        push(K_BF, t1 + 6, 3);
        record_req = 1'b1;
        play_req = 1'b1;
        @(negedge clk);
        record_req = 1'b0;
        play_req = 1'b0;
        wait_to(t1 + 5);
        pulse_stop;
        wait_to(t1 + 8);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("count_after_reset", int'(note_count), 0);
        for (int i = 0; i < 17; i++) record(i);
        chk("count_saturated", int'(note_count), 16);
        chk("full_flag", int'(full), 1);
        chk("full_idle", int'(busy), 0);

`ifdef MUSIC_SEQ_LOOP_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        record(0);
        record(1);
        t = cyc;
        push_notes(t, 2, 5);
        push(K_PF, t + 38, 0);
        push(K_BF, t + 38, 0);
        pulse_play;
        wait_to(t + 37);
        reset = 1'b1;
        @(negedge clk);
        chk("loop_reset_outputs",
            int'({ld_note, ld_play, note_counter, display_note,
                  next_note_en, note_count, full, busy}), 0);
        reset = 1'b0;
`endif

        repeat (4) @(negedge clk);
        while (q.size() > 0) begin
            ev_t e;
            e = q.pop_front();
            vecs++;
            errs++;
            $display("FAIL %s missing: got none want cyc %0d data %0d",
                     kn[e.kind], e.cyc, e.data);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
